// File: rtl/fir_pkg.sv
// fir_pkg: definitions shared by the FIR datapath and its tap feeder.
//   - default widths of the S(18,15) sample and S(28,23) coefficient formats
//   - coefficient swap FSM state encoding
//   - helpers that locate one tap or coefficient inside a packed vector
package fir_pkg;

    localparam int FIR_LEN   = 21;
    localparam int NB_IN     = 18;
    localparam int NBF_IN    = 15;
    localparam int NB_COEFF  = 28;
    localparam int NBF_COEFF = 23;

    // Coefficient swap FSM states.
    localparam logic [0:0] COEFF_IDLE    = 1'b0;
    localparam logic [0:0] COEFF_PENDING = 1'b1;

    // Widths of the packed vectors at the default sizes.
    localparam int TAPS_W  = FIR_LEN * NB_IN;
    localparam int COEFF_W = FIR_LEN * NB_COEFF;

    // LSB position of element k in a packed vector of w-bit elements.
    function automatic int pack_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered FIR coefficient storage.
//   The host writes individual coefficients into a shadow bank. A commit
//   copies the whole shadow bank into the active bank in one edge, so the
//   FIR never sees a mix of old and new coefficients.
//   While the feeder is enabled the copy is deferred to the next accepted
//   sample, so new coefficients and the new tap vector appear together.
//
// Ports:
//   clk        clock, all state on rising edge
//   i_reset    synchronous, active-low reset; clears both banks and the FSM
//   i_en       feeder enable; a commit with i_en low swaps immediately
//   i_accept   a sample is being shifted into the taps on this edge
//   i_wr       shadow write strobe
//   i_addr     shadow tap index; indices >= FIR_LEN are ignored
//   i_data     signed coefficient to write
//   i_commit   request a shadow-to-active swap
//   o_coeff    packed active bank, coeff k at [k*NB_COEFF +: NB_COEFF]
//   o_pending  a commit is waiting for its swap edge
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int FIR_LEN  = fir_pkg::FIR_LEN,
    parameter int NB_COEFF = fir_pkg::NB_COEFF,
    parameter int NB_ADDR  = $clog2(FIR_LEN)
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en,
    input  logic                         i_accept,
    input  logic                         i_wr,
    input  logic [NB_ADDR-1:0]           i_addr,
    input  logic signed [NB_COEFF-1:0]   i_data,
    input  logic                         i_commit,
    output logic [FIR_LEN*NB_COEFF-1:0]  o_coeff,
    output logic                         o_pending
);

    logic signed [NB_COEFF-1:0] shadow [FIR_LEN];
    logic signed [NB_COEFF-1:0] active [FIR_LEN];

    logic [0:0] state;
    logic [0:0] state_next;
    logic       swap;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            COEFF_IDLE: begin
                if (i_commit) begin
                    if (i_en) begin
                        state_next = COEFF_PENDING;
                    end else begin
                        // Nothing is streaming, so there is no sample boundary
                        // to wait for: swap right away.
                        swap = 1'b1;
                    end
                end
            end
            COEFF_PENDING: begin
                // Swap on the edge that shifts in the next sample, or at once
                // if the feeder is being disabled. Further commits are ignored.
                if (i_accept || !i_en) begin
                    swap       = 1'b1;
                    state_next = COEFF_IDLE;
                end
            end
            default: state_next = COEFF_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here: active[] must capture the shadow
    // contents from before this edge's write, which is exactly what
    // simultaneous register update gives.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            // NOTE: both banks are explicitly cleared on reset, so they are
            // plain flops rather than an inferred RAM; the FIR must start from
            // an all-zero coefficient set.
            for (int k = 0; k < FIR_LEN; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            state <= COEFF_IDLE;
        end else begin
            state <= state_next;
            for (int k = 0; k < FIR_LEN; k++) begin
                if (swap) begin
                    active[k] <= shadow[k];
                end
                // Out-of-range addresses match no k and are dropped.
                if (i_wr && (i_addr == NB_ADDR'(k))) begin
                    shadow[k] <= i_data;
                end
            end
        end
    end

    for (genvar k = 0; k < FIR_LEN; k++) begin : g_pack
        assign o_coeff[pack_lsb(k, NB_COEFF) +: NB_COEFF] = active[k];
    end

    assign o_pending = (state == COEFF_PENDING);

endmodule

// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: front end of the parallel-tap FIR.
//   Shifts a serial sample stream into a FIR_LEN-deep tap register, counts
//   samples until the delay line is full, and supplies the active coefficient
//   bank from fir_coeff_bank. Outputs connect straight to the FIR inputs.
//
// Ports:
//   clk              clock, all state on rising edge
//   i_reset          synchronous, active-low reset, overrides all inputs
//   i_en             global enable; low freezes taps and prime counter
//   i_valid          i_sample is valid this cycle
//   i_sample         signed input sample, S(18,15)
//   i_flush          clear taps and prime counter; a concurrent sample is dropped
//   i_coeff_wr       shadow coefficient write strobe
//   i_coeff_addr     shadow coefficient index
//   i_coeff_data     signed coefficient, S(28,23)
//   i_coeff_commit   request a shadow-to-active swap
//   o_data_reg       packed taps, tap k at [k*NB_IN +: NB_IN], k=0 newest
//   o_coeff          packed active coefficients, coeff k at [k*NB_COEFF +: NB_COEFF]
//   o_valid          one-cycle strobe: a new tap vector is present
//   o_primed         FIR_LEN samples accepted since reset or flush
//   o_coeff_pending  a commit is waiting for its swap edge
module fir_tap_feeder
    import fir_pkg::*;
#(
    parameter int FIR_LEN  = fir_pkg::FIR_LEN,
    parameter int NB_IN    = fir_pkg::NB_IN,
    parameter int NB_COEFF = fir_pkg::NB_COEFF,
    localparam int NB_ADDR = $clog2(FIR_LEN)
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic signed [NB_IN-1:0]      i_sample,
    input  logic                         i_flush,
    input  logic                         i_coeff_wr,
    input  logic [NB_ADDR-1:0]           i_coeff_addr,
    input  logic signed [NB_COEFF-1:0]   i_coeff_data,
    input  logic                         i_coeff_commit,
    output logic [FIR_LEN*NB_IN-1:0]     o_data_reg,
    output logic [FIR_LEN*NB_COEFF-1:0]  o_coeff,
    output logic                         o_valid,
    output logic                         o_primed,
    output logic                         o_coeff_pending
);

    localparam int CNT_W = $clog2(FIR_LEN + 1);

    logic signed [NB_IN-1:0] taps [FIR_LEN];
    logic [CNT_W-1:0]        count;
    logic                    accept;

    // Flush wins over a concurrent valid sample.
    assign accept = i_en && i_valid && !i_flush;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            for (int k = 0; k < FIR_LEN; k++) begin
                taps[k] <= '0;
            end
            count    <= '0;
            o_valid  <= 1'b0;
            o_primed <= 1'b0;
        end else if (i_flush) begin
            for (int k = 0; k < FIR_LEN; k++) begin
                taps[k] <= '0;
            end
            count    <= '0;
            o_valid  <= 1'b0;
            o_primed <= 1'b0;
        end else if (accept) begin
            for (int k = FIR_LEN - 1; k > 0; k--) begin
                taps[k] <= taps[k-1];
            end
            taps[0] <= i_sample;
            o_valid <= 1'b1;
            if (count != CNT_W'(FIR_LEN)) begin
                count <= count + 1'b1;
            end
            // Registered alongside count so o_primed always equals
            // (count == FIR_LEN) without a comparator on the output path.
            o_primed <= (count >= CNT_W'(FIR_LEN - 1));
        end else begin
            o_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < FIR_LEN; k++) begin : g_pack
        assign o_data_reg[pack_lsb(k, NB_IN) +: NB_IN] = taps[k];
    end

    fir_coeff_bank #(
        .FIR_LEN  (FIR_LEN),
        .NB_COEFF (NB_COEFF),
        .NB_ADDR  (NB_ADDR)
    ) u_coeff_bank (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_en      (i_en),
        .i_accept  (accept),
        .i_wr      (i_coeff_wr),
        .i_addr    (i_coeff_addr),
        .i_data    (i_coeff_data),
        .i_commit  (i_coeff_commit),
        .o_coeff   (o_coeff),
        .o_pending (o_coeff_pending)
    );

endmodule
